// File: rtl/reg_alu_sequencer_if.sv
// Instruction channel into the reg_alu micro-sequencer.
// Valid/ready handshake; all fields are qualified by instr_valid.
interface reg_alu_sequencer_if;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_kind;
    logic [1:0]  instr_op;
    logic [2:0]  instr_dst;
    logic [2:0]  instr_src_a;
    logic [2:0]  instr_src_b;
    logic [15:0] instr_imm;

    modport master (
        output instr_valid, instr_kind, instr_op, instr_dst,
               instr_src_a, instr_src_b, instr_imm,
        input  instr_ready
    );

    modport slave (
        input  instr_valid, instr_kind, instr_op, instr_dst,
               instr_src_a, instr_src_b, instr_imm,
        output instr_ready
    );
endinterface

// File: rtl/reg_alu_sequencer.sv
// Micro-sequencer stepping the reg_alu datapath through EXEC/WB/DONE for ALU and LOADI instructions.
// Latency: accept to done = EXEC_CYCLES+2 (ALU) or 2 (LOADI); one IDLE cycle between instructions.
// Backpressure: instr_ready is high only in IDLE; instr_valid while busy is ignored.
module reg_alu_sequencer #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic               clk,
    input  logic               reset,
    reg_alu_sequencer_if.slave instr,
    output logic               sel,
    output logic               wr,
    output logic [1:0]         op,
    output logic [2:0]         rd_addr_a,
    output logic [2:0]         rd_addr_b,
    output logic [2:0]         wr_addr,
    output logic [15:0]        d_in,
    input  logic               cout,
    output logic               busy,
    output logic               done,
    output logic               carry_flag,
    output logic [CNT_W-1:0]   instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] EXEC_LAST = 4'(EXEC_CYCLES - 1);

    state_t     state;
    logic [3:0] exec_cnt;
    logic       kind_q;
    logic       rdy_q;
    logic       accept;

    assign instr.instr_ready = rdy_q;
    assign accept            = instr.instr_valid & rdy_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            exec_cnt    <= 4'd0;
            kind_q      <= 1'b0;
            rdy_q       <= 1'b0;
            sel         <= 1'b0;
            wr          <= 1'b0;
            op          <= 2'b00;
            rd_addr_a   <= 3'd0;
            rd_addr_b   <= 3'd0;
            wr_addr     <= 3'd0;
            d_in        <= 16'h0000;
            busy        <= 1'b0;
            done        <= 1'b0;
            carry_flag  <= 1'b0;
            instr_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        // Every field is captured here so later input changes cannot leak in.
                        kind_q    <= instr.instr_kind;
                        op        <= instr.instr_op;
                        rd_addr_a <= instr.instr_src_a;
                        rd_addr_b <= instr.instr_src_b;
                        wr_addr   <= instr.instr_dst;
                        busy      <= 1'b1;
                        rdy_q     <= 1'b0;
                        if (instr.instr_kind) begin
                            state <= WB;
                            wr    <= 1'b1;
                            sel   <= 1'b0;
                            d_in  <= instr.instr_imm;
                        end else begin
                            state    <= EXEC;
                            exec_cnt <= EXEC_LAST;
                        end
                    end else begin
                        rdy_q <= 1'b1;
                    end
                end
                EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        state <= WB;
                        wr    <= 1'b1;
                        sel   <= 1'b1;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                WB: begin
                    // The register write and the carry capture share this edge.
                    state       <= DONE;
                    wr          <= 1'b0;
                    done        <= 1'b1;
                    instr_count <= instr_count + 1'b1;
                    if (!kind_q) begin
                        carry_flag <= cout;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rdy_q <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    wr    <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    rdy_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_alu_sequencer.sv
// Bench for reg_alu_sequencer: one default build and one EXEC_CYCLES=3 / CNT_W=2 build,
// each wired to a register-file/ALU stub and checked against an architectural reference model.
module tb_reg_alu_sequencer;

    localparam int E0 = 1;
    localparam int E1 = 3;

    typedef struct packed {
        logic        rdy;
        logic        sel;
        logic        wr;
        logic [1:0]  op;
        logic [2:0]  ra;
        logic [2:0]  rb;
        logic [2:0]  wa;
        logic [15:0] din;
        logic        busy;
        logic        done;
        logic        cf;
        logic [7:0]  cnt;
    } obs_t;

    localparam obs_t ZERO = '0;

    logic clk;
    logic reset;
    int   nchk;
    int   nerr;

    reg_alu_sequencer_if ifa ();
    reg_alu_sequencer_if ifb ();

    logic        v_valid [2];
    logic        v_kind  [2];
    logic [1:0]  v_op    [2];
    logic [2:0]  v_dst   [2];
    logic [2:0]  v_sa    [2];
    logic [2:0]  v_sb    [2];
    logic [15:0] v_imm   [2];

    assign ifa.instr_valid = v_valid[0];
    assign ifa.instr_kind  = v_kind[0];
    assign ifa.instr_op    = v_op[0];
    assign ifa.instr_dst   = v_dst[0];
    assign ifa.instr_src_a = v_sa[0];
    assign ifa.instr_src_b = v_sb[0];
    assign ifa.instr_imm   = v_imm[0];
    assign ifb.instr_valid = v_valid[1];
    assign ifb.instr_kind  = v_kind[1];
    assign ifb.instr_op    = v_op[1];
    assign ifb.instr_dst   = v_dst[1];
    assign ifb.instr_src_a = v_sa[1];
    assign ifb.instr_src_b = v_sb[1];
    assign ifb.instr_imm   = v_imm[1];

    logic        sel0, wr0, busy0, done0, cf0, cout0;
    logic [1:0]  op0;
    logic [2:0]  ra0, rb0, wa0;
    logic [15:0] din0;
    logic [7:0]  cnt0;
    logic        sel1, wr1, busy1, done1, cf1, cout1;
    logic [1:0]  op1;
    logic [2:0]  ra1, rb1, wa1;
    logic [15:0] din1;
    logic [1:0]  cnt1;

    reg_alu_sequencer #(.EXEC_CYCLES(E0), .CNT_W(8)) u_a (
        .clk(clk), .reset(reset), .instr(ifa.slave),
        .sel(sel0), .wr(wr0), .op(op0), .rd_addr_a(ra0), .rd_addr_b(rb0),
        .wr_addr(wa0), .d_in(din0), .cout(cout0), .busy(busy0), .done(done0),
        .carry_flag(cf0), .instr_count(cnt0)
    );

    reg_alu_sequencer #(.EXEC_CYCLES(E1), .CNT_W(2)) u_b (
        .clk(clk), .reset(reset), .instr(ifb.slave),
        .sel(sel1), .wr(wr1), .op(op1), .rd_addr_a(ra1), .rd_addr_b(rb1),
        .wr_addr(wa1), .d_in(din1), .cout(cout1), .busy(busy1), .done(done1),
        .carry_flag(cf1), .instr_count(cnt1)
    );

    obs_t ob [2];
    assign ob[0] = {ifa.instr_ready, sel0, wr0, op0, ra0, rb0, wa0, din0, busy0, done0, cf0, cnt0};
    assign ob[1] = {ifb.instr_ready, sel1, wr1, op1, ra1, rb1, wa1, din1, busy1, done1, cf1, {6'b0, cnt1}};

    // ALU op semantics: 00 add, 01 sub (carry = no borrow), 10 and, 11 or.
    function automatic logic [16:0] alu(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
        case (o)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} + {1'b0, ~b} + 17'd1;
            2'b10:   return {1'b0, a & b};
            default: return {1'b0, a | b};
        endcase
    endfunction

    // Datapath stub: register file plus ALU driven by the sequencer outputs.
    logic [15:0] rf [2][8];
    logic [16:0] res0, res1;
    assign res0  = alu(op0, rf[0][ra0], rf[0][rb0]);
    assign res1  = alu(op1, rf[1][ra1], rf[1][rb1]);
    assign cout0 = res0[16];
    assign cout1 = res1[16];

    always @(posedge clk) begin
        if (wr0) rf[0][wa0] <= sel0 ? res0[15:0] : din0;
        if (wr1) rf[1][wa1] <= sel1 ? res1[15:0] : din1;
    end

    // Architectural reference state.
    logic [15:0] ref_rf  [2][8];
    logic [7:0]  ref_cnt [2];
    logic        ref_cf  [2];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic fail(input string tag, input logic [63:0] o, input logic [63:0] e);
        nerr++;
        $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    endtask

    task automatic drive(input int w, input logic vl, input logic k, input logic [1:0] o,
                         input logic [2:0] d, input logic [2:0] a, input logic [2:0] b,
                         input logic [15:0] im);
        v_valid[w] = vl;
        v_kind[w]  = k;
        v_op[w]    = o;
        v_dst[w]   = d;
        v_sa[w]    = a;
        v_sb[w]    = b;
        v_imm[w]   = im;
    endtask

    task automatic scramble(input int w, input logic vl);
        drive(w, vl, 1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 16'($urandom));
    endtask

    task automatic reset_ref();
        for (int w = 0; w < 2; w++) begin
            ref_cnt[w] = 8'd0;
            ref_cf[w]  = 1'b0;
        end
    endtask

    // Issue one instruction and check every cycle up to and including DONE.
    task automatic run(input int w, input logic kind, input logic [1:0] opv, input logic [2:0] dst,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [15:0] imm, input bit hold);
        int          lat;
        int          n;
        logic [16:0] res;
        logic [15:0] exp_wd;
        lat = kind ? 2 : ((w == 0) ? E0 : E1) + 2;
        n   = 0;
        @(negedge clk);
        while (!ob[w].rdy && n < 50) begin
            @(negedge clk);
            n++;
        end
        nchk++; if (ob[w].rdy !== 1'b1) fail("ready_wait", ob[w].rdy, 1'b1);
        drive(w, 1'b1, kind, opv, dst, sa, sb, imm);
        @(posedge clk);
        #1;
        scramble(w, hold ? 1'b1 : 1'b0);
        res    = alu(opv, ref_rf[w][sa], ref_rf[w][sb]);
        exp_wd = kind ? imm : res[15:0];
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            nchk++; if (ob[w].busy !== 1'b1) fail("busy", ob[w].busy, 1'b1);
            nchk++; if (ob[w].rdy !== 1'b0) fail("ready_low", ob[w].rdy, 1'b0);
            if (k <= lat - 2) begin
                nchk++; if (ob[w].wr !== 1'b0) fail("exec_wr", ob[w].wr, 1'b0);
                nchk++; if (ob[w].done !== 1'b0) fail("exec_done", ob[w].done, 1'b0);
                nchk++; if (ob[w].ra !== sa) fail("exec_ra", ob[w].ra, sa);
                nchk++; if (ob[w].rb !== sb) fail("exec_rb", ob[w].rb, sb);
                nchk++; if (ob[w].op !== opv) fail("exec_op", ob[w].op, opv);
            end else if (k == lat - 1) begin
                nchk++; if (ob[w].wr !== 1'b1) fail("wb_wr", ob[w].wr, 1'b1);
                nchk++; if (ob[w].done !== 1'b0) fail("wb_done", ob[w].done, 1'b0);
                nchk++; if (ob[w].wa !== dst) fail("wb_addr", ob[w].wa, dst);
                nchk++; if (ob[w].sel !== ~kind) fail("wb_sel", ob[w].sel, ~kind);
                if (kind) begin
                    nchk++; if (ob[w].din !== imm) fail("wb_din", ob[w].din, imm);
                end else begin
                    nchk++; if (ob[w].ra !== sa) fail("wb_ra", ob[w].ra, sa);
                    nchk++; if (ob[w].rb !== sb) fail("wb_rb", ob[w].rb, sb);
                    nchk++; if (ob[w].op !== opv) fail("wb_op", ob[w].op, opv);
                end
            end else begin
                ref_rf[w][dst] = exp_wd;
                ref_cnt[w]     = (ref_cnt[w] + 8'd1) & ((w == 0) ? 8'hFF : 8'h03);
                if (!kind) ref_cf[w] = res[16];
                nchk++; if (ob[w].done !== 1'b1) fail("done_pulse", ob[w].done, 1'b1);
                nchk++; if (ob[w].wr !== 1'b0) fail("done_wr", ob[w].wr, 1'b0);
                nchk++; if (ob[w].cnt !== ref_cnt[w]) fail("count", ob[w].cnt, ref_cnt[w]);
                nchk++; if (ob[w].cf !== ref_cf[w]) fail("carry", ob[w].cf, ref_cf[w]);
                nchk++; if (rf[w][dst] !== exp_wd) fail("regfile", rf[w][dst], exp_wd);
                if (hold) drive(w, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0);
            end
        end
        if (hold) begin
            @(negedge clk);
            nchk++; if (ob[w].busy !== 1'b0) fail("hold_idle_busy", ob[w].busy, 1'b0);
            nchk++; if (ob[w].rdy !== 1'b1) fail("hold_idle_ready", ob[w].rdy, 1'b1);
            nchk++; if (ob[w].cnt !== ref_cnt[w]) fail("hold_single_count", ob[w].cnt, ref_cnt[w]);
        end
    endtask

    initial begin
        logic [7:0] seq6 [5];
        nchk  = 0;
        nerr  = 0;
        reset = 1'b1;
        for (int w = 0; w < 2; w++) drive(w, 1'b0, 1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 16'h0);
        reset_ref();
        seq6 = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd1};

        // Reset state
        #12;
        nchk++; if (ob[0] !== ZERO) fail("reset_a", ob[0], ZERO);
        nchk++; if (ob[1] !== ZERO) fail("reset_b", ob[1], ZERO);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nchk++; if (ob[0].rdy !== 1'b1) fail("ready_after_reset_a", ob[0].rdy, 1'b1);
        nchk++; if (ob[1].rdy !== 1'b1) fail("ready_after_reset_b", ob[1].rdy, 1'b1);

        // LOADI then dependent ALU add with carry out
        run(0, 1'b1, 2'b00, 3'd1, 3'd0, 3'd0, 16'h00FF, 1'b0);
        nchk++; if (ob[0].cnt !== 8'd1) fail("t1_count", ob[0].cnt, 8'd1);
        run(0, 1'b1, 2'b00, 3'd2, 3'd0, 3'd0, 16'hFF01, 1'b0);
        run(0, 1'b0, 2'b00, 3'd3, 3'd1, 3'd2, 16'h0000, 1'b0);
        nchk++; if (rf[0][3] !== 16'h0000) fail("t2_r3", rf[0][3], 16'h0000);
        nchk++; if (ob[0].cf !== 1'b1) fail("t2_carry", ob[0].cf, 1'b1);

        // Fill remaining registers of both datapaths
        for (int r = 0; r < 8; r++) begin
            if (r != 1 && r != 2 && r != 3) run(0, 1'b1, 2'b00, 3'(r), 3'd0, 3'd0, 16'($urandom), 1'b0);
            run(1, 1'b1, 2'b00, 3'(r), 3'd0, 3'd0, 16'($urandom), 1'b0);
        end

        // Longer EXEC phase, then valid held high through an instruction
        run(1, 1'b0, 2'b00, 3'd5, 3'd1, 3'd2, 16'h0, 1'b0);
        run(1, 1'b0, 2'b01, 3'd6, 3'd3, 3'd4, 16'h0, 1'b1);

        // Reset during EXEC drops the instruction
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 2'b00, 3'd4, 3'd1, 3'd2, 16'h0);
        @(posedge clk);
        #1;
        scramble(0, 1'b0);
        @(negedge clk);
        nchk++; if (ob[0].busy !== 1'b1) fail("t5_in_exec", ob[0].busy, 1'b1);
        reset = 1'b1;
        #1;
        reset_ref();
        nchk++; if (ob[0] !== ZERO) fail("t5_reset_a", ob[0], ZERO);
        nchk++; if (ob[1] !== ZERO) fail("t5_reset_b", ob[1], ZERO);
        nchk++; if (rf[0][4] !== ref_rf[0][4]) fail("t5_no_write", rf[0][4], ref_rf[0][4]);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        nchk++; if (ob[0].rdy !== 1'b1) fail("t5_ready", ob[0].rdy, 1'b1);
        run(0, 1'b1, 2'b00, 3'd4, 3'd0, 3'd0, 16'h1234, 1'b0);

        // Narrow counter wraps
        for (int i = 0; i < 5; i++) begin
            run(1, 1'b1, 2'b00, 3'(i), 3'd0, 3'd0, 16'($urandom), 1'b0);
            nchk++; if (ob[1].cnt !== seq6[i]) fail("t6_count", ob[1].cnt, seq6[i]);
            nchk++; if (ob[1].cf !== 1'b0) fail("t6_carry", ob[1].cf, 1'b0);
        end
        run(1, 1'b1, 2'b00, 3'd0, 3'd0, 3'd0, 16'hFFFF, 1'b0);
        run(1, 1'b0, 2'b00, 3'd7, 3'd0, 3'd0, 16'h0, 1'b0);
        nchk++; if (ob[1].cf !== 1'b1) fail("t6_carry_set", ob[1].cf, 1'b1);

        // Random instruction streams
        for (int i = 0; i < 30; i++) begin
            for (int w = 0; w < 2; w++) begin
                run(w, 1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
                    16'($urandom), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
